// File: rtl/wide_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding and the datapath slice width.
package wide_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational NIB_W-bit ripple-carry adder; the one shared datapath slice
// that the sequencer steps across the operand nibbles.
module ripple_carry_adder
    import wide_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[NIB_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built around one shared 4-bit adder,
// processing one nibble per clock LSB first, with valid/ready request/response.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    state_t state_reg, state_next;

    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic             accept;
    logic             last_pass;

    logic [NIB_W-1:0] a_nib [NNIB];
    logic [NIB_W-1:0] b_nib [NNIB];
    logic [NIB_W-1:0] add_a;
    logic [NIB_W-1:0] add_b;
    logic [NIB_W-1:0] add_sum;
    logic             add_cout;

    generate
        for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
            assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];
        end
    endgenerate

    assign add_a = a_nib[idx_reg];
    assign add_b = b_nib[idx_reg];

    ripple_carry_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept    = start_valid && start_ready;
    assign last_pass = (state_reg == RUN) && (idx_reg == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_pass) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is folded in at accept time: B is inverted once and the
    // carry flop seeded with 1, so RUN only ever adds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            a_reg     <= op_a;
            b_reg     <= op_b ^ {WIDTH{sub}};
            carry_reg <= sub | cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            for (int i = 0; i < NNIB; i++) begin
                if (idx_reg == IDX_W'(i)) begin
                    result_reg[i*NIB_W +: NIB_W] <= add_sum;
                end
            end
            carry_reg <= add_cout;
            if (last_pass) begin
                // idx parks on the last nibble; it is only cleared by the next accept
                cout_reg <= add_cout;
                ovf_reg  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ add_sum[NIB_W-1] ^ add_cout;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign result = result_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WIDTH=16): directed corner cases,
// response stalls, mid-operation reset and randomized traffic vs. an arithmetic model.
module tb_wide_add_sequencer;

    localparam int W    = 16;
    localparam int NNIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf)
    );

    // Reference: plain wide arithmetic; overflow from the sign rule
    // (operands of equal sign producing a result of the other sign).
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] addend;
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         o;
        addend = s ? (~b) : b;
        full   = {1'b0, a} + {1'b0, addend} + (W+1)'(s ? 1'b1 : c);
        r      = full[W-1:0];
        o      = (a[W-1] == addend[W-1]) && (r[W-1] != a[W-1]);
        return {o, full[W], r};
    endfunction

    // Drives one request from a negedge and waits for res_valid; lat counts
    // rising edges after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output int lat, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        lat = 0;
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            timed_out = 1'b1;
            return;
        end
        op_a = a;
        op_b = b;
        cin = c;
        sub = s;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) timed_out = 1'b1;
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b valid=%b result=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     start_ready, res_valid, result, cout, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h8000};
        logic [W-1:0] tb [6] = '{16'h0FED, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
        logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] er [6] = '{16'h2221, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h7FFF};
        logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], tc[i], ts[i], lat, to);
            n_cmp++;
            if (to) begin
                n_fail++;
                $display("FAIL directed_timeout[%0d]: no result within bound", i);
                continue;
            end
            $display("directed %0d: %h %s %h cin=%b -> %h cout=%b ovf=%b lat=%0d",
                     i, ta[i], ts[i] ? "-" : "+", tb[i], tc[i], result, cout, ovf, lat);
            n_cmp++;
            if (lat != NNIB) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, NNIB);
            end
            n_cmp++;
            if (result !== er[i] || cout !== ec[i] || ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h/%b/%b, want %h/%b/%b",
                         i, result, cout, ovf, er[i], ec[i], eo[i]);
            end
            take();
            n_cmp++;
            if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_release[%0d]: got ready=%b valid=%b, want 1 0",
                         i, start_ready, res_valid);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        bit to;
        issue(16'h1234, 16'h0FED, 1'b0, 1'b0, lat, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL stall_timeout: no result within bound");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            start_valid = ~start_valid;
            op_a = W'($urandom);
            op_b = W'($urandom);
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b1 || start_ready !== 1'b0 || result !== 16'h2221 ||
                cout !== 1'b0 || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b ready=%b result=%h, want 1 0 2221",
                         i, res_valid, start_ready, result);
            end
        end
        start_valid = 1'b0;
        take();
        n_cmp++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got ready=%b valid=%b, want 1 0", start_ready, res_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_accept: got ready=%b, want 1 (no stray accept)", start_ready);
        end
        $display("stall: result held at %h through 5 stalled cycles", result);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        op_a = 16'hABCD;
        op_b = 16'h1111;
        cin = 1'b0;
        sub = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (result !== '0 || cout !== 1'b0 || ovf !== 1'b0 || res_valid !== 1'b0 ||
            start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset: got result=%h cout=%b ovf=%b valid=%b ready=%b, want 0000 0 0 0 1",
                     result, cout, ovf, res_valid, start_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_no_valid[%0d]: got valid=%b, want 0", i, res_valid);
            end
        end
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, lat, to);
        n_cmp++;
        if (to || result !== 16'h0002 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_recover: got timeout=%b result=%h cout=%b ovf=%b, want 0 0002 0 0",
                     to, result, cout, ovf);
        end
        $display("reset mid-run: recovery 0001+0001 -> %h", result);
        take();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         c, s;
        logic [W+1:0] exp;
        int           lat;
        bit           to;
        int           stall;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            exp = model(a, b, c, s);
            issue(a, b, c, s, lat, to);
            n_cmp++;
            if (to) begin
                n_fail++;
                $display("FAIL b2b_timeout[%0d]: no result within bound", i);
                return;
            end
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) @(negedge clk);
            $display("op %0d: %h %s %h cin=%b -> %h cout=%b ovf=%b", i, a, s ? "-" : "+", b, c,
                     result, cout, ovf);
            n_cmp++;
            if (lat != NNIB || res_valid !== 1'b1 || result !== exp[W-1:0] ||
                cout !== exp[W] || ovf !== exp[W+1]) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %h/%b/%b lat=%0d, want %h/%b/%b lat=%0d",
                         i, result, cout, ovf, lat, exp[W-1:0], exp[W], exp[W+1], NNIB);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
